stopwatch_core: RTL and testbench
=================================

# stopwatch_core

Minutes:seconds BCD stopwatch that sits directly downstream of the clock divider (`ClockModule`). It samples the divider's `clk_out` as a data strobe (`tick_in`) in the `clk_in` domain and advances a four-digit BCD time on every `TICKS_PER_STEP` rising edges of that strobe. It takes start/stop and clear pulses from the button debouncers and drives the seven-segment display stage.

## Interface
Parameters:
- `TICKS_PER_STEP`, default 100: number of `tick_in` rising edges per one-second increment. Legal range is 1 to 65535; the prescaler is 16 bits.

Ports:
- `clk_in`, input, 1: system clock (100 MHz). This is the only clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `tick_in`, input, 1: divider output, treated as data and edge-detected internally.
- `start_stop`, input, 1: one-cycle pulse that toggles between running and paused.
- `clear`, input, 1: one-cycle pulse that zeroes the time and returns the block to IDLE.
- `lap`, input, 1: one-cycle pulse that toggles the lap hold. Used only with `STOPWATCH_LAP_EN`.
- `digits`, output, 16: display value as {min_tens, min_ones, sec_tens, sec_ones}, 4-bit BCD each.
- `running`, output, 1: high in the RUN state.
- `wrap_pulse`, output, 1: one-cycle pulse when the time wraps from 59:59 to 00:00.
- `lap_active`, output, 1: high while the display is frozen.

## Operation
- **Tick input path:**
  - `tick_in` passes through flops s1, s2, s3.
  - rise = s2 & ~s3. Only rising edges count.
- **State machine:** IDLE, RUN, PAUSE.
  - IDLE + `start_stop` goes to RUN.
  - RUN + `start_stop` goes to PAUSE.
  - PAUSE + `start_stop` goes to RUN.
  - `clear` in any state goes to IDLE and zeroes the time and the prescaler.
  - `clear` has priority over `start_stop` in the same cycle.
- **Counting:**
  - Counting is decided by the state before the clock edge.
  - In RUN, each rise increments the prescaler.
  - When the prescaler equals `TICKS_PER_STEP`-1 and a rise arrives, the prescaler goes to 0 and the time increments.
  - A rise in the same cycle as IDLE→RUN is not counted.
  - A rise in the same cycle as RUN→PAUSE is counted.
- **BCD increment with ripple carry:**
  - sec_ones 9→0, carry.
  - sec_tens 5→0, carry.
  - min_ones 9→0, carry.
  - min_tens 5→0: the time is 00:00 and `wrap_pulse` is high for one cycle.
  - After wrap the block stays in RUN.
  - No digit ever holds a non-BCD value.
- **PAUSE:** time and prescaler are held. Rises are ignored, not queued.
- **Outputs:** `running` = (state == RUN). `digits` shows the live time unless the lap hold is active.

## Timing
- **Reset values:** state IDLE, time 00:00, prescaler 0, s1/s2/s3 = 0. `digits` = 16'h0000, `running` = 0, `wrap_pulse` = 0, `lap_active` = 0.
- **Reset mid-count:** asserting `rst_n` low mid-count clears everything immediately, without waiting for a clock.
- **Tick latency:** `tick_in` is first sampled high at `clk_in` edge k. The counted increment appears on `digits` after edge k+2.
- **Control pulses:** `start_stop` and `clear` act on the edge where they are sampled high. `running` reflects the new state after that edge.
- **Outputs are registered:** `wrap_pulse` is registered and aligned with the 00:00 update on `digits`.
- **Minimum tick rate:** `tick_in` high and low phases must each be at least 2 `clk_in` cycles. Otherwise rises are not guaranteed.

## Configuration
- Macro: `STOPWATCH_LAP_EN`.
- **Defined:**
  - `lap` in RUN captures the current time into a hold register and sets `lap_active`. `digits` then shows the hold register while counting continues.
  - A second `lap` clears `lap_active`, and `digits` shows the live time on the next cycle.
  - `lap` in IDLE or PAUSE is ignored.
  - `clear` also drops `lap_active`.
  - `start_stop` does not affect the hold.
- **Undefined:** `lap` is ignored, `lap_active` is tied to 0, no hold register is built, and `digits` always shows the live time.

## Test plan
Use `TICKS_PER_STEP`=2 and drive `tick_in` from `ClockModule` DIVIDE_BY(4).
- Reset, then `start_stop`, then 6 `tick_in` rising edges → `digits` = 16'h0003, `running` = 1.
- Preload by counting to 16'h5959, then 2 more rises → `digits` = 16'h0000, `wrap_pulse` high exactly 1 cycle, `running` still 1.
- RUN, then `start_stop`, then 10 rises → `digits` unchanged. `start_stop` again → counting resumes from the held prescaler.
- `clear` and `start_stop` in the same cycle while in RUN → state IDLE, `digits` = 0, `running` = 0.
- `rst_n` pulsed low mid-count at 16'h0127 → all outputs 0 immediately, with no clock edge required.
- With `STOPWATCH_LAP_EN`: at 16'h0010 pulse `lap`, then 4 rises → `digits` = 16'h0010, `lap_active` = 1. `lap` again → `digits` = 16'h0012.

Source files
------------

// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS BCD stopwatch advanced by a prescaled, edge-detected
// tick strobe sampled in the clk_in domain.
// Optional lap-hold display freeze is built when STOPWATCH_LAP_EN is defined;
// without it, lap is ignored and lap_active is tied low.
module stopwatch_core #(
    parameter int unsigned TICKS_PER_STEP = 100
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        tick_in,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [15:0] digits,
    output logic        running,
    output logic        wrap_pulse,
    output logic        lap_active
);

    localparam logic [15:0] PRE_LAST = 16'(TICKS_PER_STEP - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    logic        r_s1;
    logic        r_s2;
    logic        r_s3;
    logic [1:0]  r_state;
    logic [15:0] r_pre;
    logic [15:0] r_time;
    logic        r_wrap;

    logic        w_rise;
    logic        w_count;
    logic [16:0] w_time_inc;

    // One-second BCD increment with ripple carry; bit 16 flags the 59:59 -> 00:00 wrap.
    // Comparisons use >= so a corrupted digit can never stick outside 0..9 / 0..5.
    function automatic logic [16:0] bcd_inc(input logic [15:0] t);
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        logic [3:0] d3;
        logic       c;
        d0 = t[3:0];
        d1 = t[7:4];
        d2 = t[11:8];
        d3 = t[15:12];
        c  = 1'b1;
        if (d0 >= 4'd9) begin
            d0 = 4'd0;
        end else begin
            d0 = d0 + 4'd1;
            c  = 1'b0;
        end
        if (c) begin
            if (d1 >= 4'd5) begin
                d1 = 4'd0;
            end else begin
                d1 = d1 + 4'd1;
                c  = 1'b0;
            end
        end
        if (c) begin
            if (d2 >= 4'd9) begin
                d2 = 4'd0;
            end else begin
                d2 = d2 + 4'd1;
                c  = 1'b0;
            end
        end
        if (c) begin
            if (d3 >= 4'd5) begin
                d3 = 4'd0;
            end else begin
                d3 = d3 + 4'd1;
                c  = 1'b0;
            end
        end
        return {c, d3, d2, d1, d0};
    endfunction

    assign w_rise     = r_s2 & ~r_s3;
    assign w_count    = (r_state == ST_RUN) && w_rise;
    assign w_time_inc = bcd_inc(r_time);

    // Synchronise the divider output and keep one extra stage for edge detection.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= tick_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Run/pause state machine; clear wins over start_stop.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (clear) begin
            r_state <= ST_IDLE;
        end else if (start_stop) begin
            case (r_state)
                ST_IDLE:  r_state <= ST_RUN;
                ST_RUN:   r_state <= ST_PAUSE;
                ST_PAUSE: r_state <= ST_RUN;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Prescaler and time advance, gated by the state held before this edge.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_pre  <= 16'd0;
            r_time <= 16'h0000;
            r_wrap <= 1'b0;
        end else if (clear) begin
            r_pre  <= 16'd0;
            r_time <= 16'h0000;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_count) begin
                if (r_pre >= PRE_LAST) begin
                    r_pre  <= 16'd0;
                    r_time <= w_time_inc[15:0];
                    r_wrap <= w_time_inc[16];
                end else begin
                    r_pre <= r_pre + 16'd1;
                end
            end
        end
    end

    assign running    = (r_state == ST_RUN);
    assign wrap_pulse = r_wrap;

`ifdef STOPWATCH_LAP_EN
    logic        r_lap_active;
    logic [15:0] r_hold;

    // Lap hold: toggled only while running, captures the live time on entry.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_lap_active <= 1'b0;
            r_hold       <= 16'h0000;
        end else if (clear) begin
            r_lap_active <= 1'b0;
        end else if (lap && (r_state == ST_RUN)) begin
            if (r_lap_active) begin
                r_lap_active <= 1'b0;
            end else begin
                r_lap_active <= 1'b1;
                r_hold       <= r_time;
            end
        end
    end

    assign digits     = r_lap_active ? r_hold : r_time;
    assign lap_active = r_lap_active;
`else
    logic w_unused_lap;
    assign w_unused_lap = lap;
    assign digits       = r_time;
    assign lap_active   = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: stimulus tasks update a time-in-ticks
// reference model and queue cycle-stamped expectations; a monitor process
// compares them against the DUT outputs.
module tb_stopwatch_core;

    localparam int TPS = 2;

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_in = 1'b0;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        lap = 1'b0;
    logic [15:0] digits;
    logic        running;
    logic        wrap_pulse;
    logic        lap_active;

    stopwatch_core #(.TICKS_PER_STEP(TPS)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .tick_in    (tick_in),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .digits     (digits),
        .running    (running),
        .wrap_pulse (wrap_pulse),
        .lap_active (lap_active)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct packed {
        int          stamp;
        logic [15:0] dig;
        logic        run;
        logic        wrap;
        logic        lapa;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    failures = 0;

    // Reference model: state 0=IDLE 1=RUN 2=PAUSE, time kept as total counted ticks.
    int m_state = 0;
    int m_total = 0;
    bit m_lap = 1'b0;
    int m_hold = 0;

    function automatic int m_secs();
        return (m_total / TPS) % 3600;
    endfunction

    function automatic logic [15:0] bcd(input int secs);
        int mm;
        int ss;
        mm = secs / 60;
        ss = secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [15:0] disp();
        return m_lap ? bcd(m_hold) : bcd(m_secs());
    endfunction

    task automatic push(input string nm, input logic [15:0] d, input logic r,
                        input logic w, input logic l);
        exp_t e;
        e.stamp = cyc;
        e.dig   = d;
        e.run   = r;
        e.wrap  = w;
        e.lapa  = l;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // All tasks start and end just after a rising clock edge.
    task automatic do_rise(input int hi, input int lo, input bit ss_k2);
        logic [15:0] d_old;
        logic [15:0] d_new;
        logic        r_old;
        logic        r_new;
        bit          wrapped;
        d_old   = disp();
        r_old   = (m_state == 1);
        wrapped = 1'b0;
        if (m_state == 1) begin
            m_total++;
            if (m_total % (TPS * 3600) == 0) wrapped = 1'b1;
        end
        if (ss_k2) m_state = (m_state == 1) ? 2 : 1;
        d_new = disp();
        r_new = (m_state == 1);
        tick_in = 1'b1;
        for (int j = 0; j < hi + lo; j++) begin
            @(posedge clk_in);
            #1;
            if (j == hi - 1) tick_in = 1'b0;
            if (ss_k2 && j == 1) start_stop = 1'b1;
            if (ss_k2 && j == 2) start_stop = 1'b0;
            if (j < 4)
                push(ss_k2 ? "rise_ss" : "rise", (j >= 2) ? d_new : d_old,
                     (j >= 2) ? r_new : r_old, wrapped && (j == 2), m_lap);
        end
    endtask

    task automatic rand_rise(input bit ss_k2);
        do_rise(int'($urandom_range(2, 4)), int'($urandom_range(2, 4)), ss_k2);
    endtask

    task automatic pulse(input string nm, input bit ss, input bit clr, input bit lp);
        int old_state;
        start_stop = ss;
        clear      = clr;
        lap        = lp;
        @(posedge clk_in);
        #1;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        old_state  = m_state;
        if (clr) begin
            m_state = 0;
            m_total = 0;
            m_lap   = 1'b0;
        end else begin
            if (ss) m_state = (m_state == 1) ? 2 : 1;
`ifdef STOPWATCH_LAP_EN
            if (lp && old_state == 1) begin
                if (m_lap) begin
                    m_lap = 1'b0;
                end else begin
                    m_lap  = 1'b1;
                    m_hold = m_secs();
                end
            end
`endif
        end
        push(nm, disp(), m_state == 1, 1'b0, m_lap);
    endtask

    task automatic idle_cycles(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk_in);
            #1;
            push("idle", disp(), m_state == 1, 1'b0, m_lap);
        end
    endtask

    // Monitor: compare every expectation whose cycle stamp has come due.
    initial begin : monitor
        exp_t  it;
        string nm;
        forever begin
            @(negedge clk_in or negedge rst_n);
            #1;
            while (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
                it = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if (digits !== it.dig || running !== it.run ||
                    wrap_pulse !== it.wrap || lap_active !== it.lapa) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got dig=%h run=%b wrap=%b lap=%b want dig=%h run=%b wrap=%b lap=%b",
                             nm, cyc, digits, running, wrap_pulse, lap_active,
                             it.dig, it.run, it.wrap, it.lapa);
                end
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog cyc=%0d got no_finish want finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int n;
        int r;
        // Power-on reset values
        repeat (3) @(posedge clk_in);
        #1;
        push("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk_in);
        #2;
        rst_n = 1'b1;
        @(posedge clk_in);
        #1;

        // Rises in IDLE are ignored, then start and count six rises
        for (int i = 0; i < 3; i++) rand_rise(1'b0);
        pulse("start", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) rand_rise(1'b0);
        idle_cycles(2);

        // Pause with odd prescaler, rises ignored, resume from held prescaler
        rand_rise(1'b0);
        pulse("pause", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) rand_rise(1'b0);
        pulse("resume", 1'b1, 1'b0, 1'b0);
        rand_rise(1'b0);
        rand_rise(1'b0);

        // Rise coincident with RUN->PAUSE counts; with IDLE->RUN it does not
        rand_rise(1'b1);
        rand_rise(1'b1);
        pulse("clear", 1'b0, 1'b1, 1'b0);
        rand_rise(1'b1);
        rand_rise(1'b0);

        // clear and start_stop together while running
        pulse("clr_ss", 1'b1, 1'b1, 1'b0);
        idle_cycles(2);

        // Lap hold (ignored when the option is not built)
        pulse("start", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) do_rise(2, 2, 1'b0);
        pulse("lap_on", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) rand_rise(1'b0);
        pulse("lap_off", 1'b0, 1'b0, 1'b1);
        pulse("pause", 1'b1, 1'b0, 1'b0);
        pulse("lap_paused", 1'b0, 1'b0, 1'b1);
        pulse("resume", 1'b1, 1'b0, 1'b0);
        pulse("lap_on2", 1'b0, 1'b0, 1'b1);
        rand_rise(1'b0);
        pulse("lap_clear", 1'b0, 1'b1, 1'b0);

        // Count to 59:59 then wrap to 00:00 with a one-cycle wrap_pulse
        pulse("start", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3600 * TPS - 2; i++) do_rise(2, 2, 1'b0);
        idle_cycles(1);
        do_rise(2, 2, 1'b0);
        do_rise(2, 3, 1'b0);
        idle_cycles(2);
        do_rise(2, 2, 1'b0);

        // Asynchronous reset mid-count at 01:27
        pulse("clear", 1'b0, 1'b1, 1'b0);
        pulse("start", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 87 * TPS; i++) do_rise(2, 2, 1'b0);
        tick_in = 1'b1;
        @(posedge clk_in);
        #1;
        m_state = 0;
        m_total = 0;
        m_lap   = 1'b0;
        push("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        #1;
        rst_n   = 1'b0;
        tick_in = 1'b0;
        @(posedge clk_in);
        #1;
        push("reset_hold", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk_in);
        #2;
        rst_n = 1'b1;
        @(posedge clk_in);
        #1;
        idle_cycles(3);

        // Randomised mix of rises, toggles, laps and occasional clears
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 19));
            if (r < 12) begin
                rand_rise(1'b0);
            end else if (r < 14) begin
                rand_rise(1'b1);
            end else if (r < 16) begin
                pulse("rnd_ss", 1'b1, 1'b0, 1'b0);
            end else if (r < 18) begin
                pulse("rnd_lap", 1'b0, 1'b0, 1'b1);
            end else if (r == 18) begin
                pulse("rnd_clr", 1'b0, 1'b1, 1'b0);
            end else begin
                n = int'($urandom_range(1, 3));
                idle_cycles(n);
            end
        end

        // Drain the scoreboard within a bounded number of cycles
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(posedge clk_in);
            n++;
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain got pending=%0d want pending=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
